// File: rtl/swacc_mr_mpt_query.sv
// MPT read-back engine: CEU query -> ICM address lookup -> MPT cache get -> two-beat CEU response.
// Outputs are registered copies of the next-state decode, so each one tracks the current state only.
module swacc_mr_mpt_query #(
    parameter int unsigned HEAD_W = 128,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned IDX_W  = 19,
    parameter int unsigned ICM_W  = 64,
    parameter int unsigned PHY_W  = 64,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [HEAD_W-1:0]                    cmd_head,
    output logic                                 icm_lookup_valid,
    input  logic                                 icm_lookup_ready,
    output logic [IDX_W-1:0]                     icm_lookup_head,
    input  logic                                 icm_rsp_valid,
    output logic                                 icm_rsp_ready,
    input  logic [ICM_W-1:0]                     icm_rsp_icm_addr,
    input  logic [PHY_W-1:0]                     icm_rsp_phy_addr,
    output logic                                 cache_get_req_valid,
    input  logic                                 cache_get_req_ready,
    output logic [TAG_W+2*CNT_W+PHY_W+ICM_W-1:0] cache_get_req_head,
    input  logic                                 cache_get_rsp_valid,
    output logic                                 cache_get_rsp_ready,
    input  logic [2*DATA_W-1:0]                  cache_get_rsp_data,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [HEAD_W-1:0]                    rsp_head,
    output logic [DATA_W-1:0]                    rsp_data,
    output logic                                 rsp_last,
    output logic                                 err_opcode
);

    localparam int unsigned ENTRY_W = 2 * DATA_W;
    localparam int unsigned CHEAD_W = TAG_W + 2 * CNT_W + PHY_W + ICM_W;
    localparam logic [3:0]  RD_MPT_QUERY = 4'h1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_REQ,
        ADDR_RSP,
        CACHE_GET,
        CACHE_RSP,
        BEAT0,
        BEAT1
    } state_t;

    state_t               state_q, state_d;
    logic [HEAD_W-1:0]    head_q, head_d;
    logic [ICM_W-1:0]     icm_q, icm_d;
    logic [PHY_W-1:0]     phy_q, phy_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;

    logic                 cmd_ready_d;
    logic                 icm_lookup_valid_d;
    logic [IDX_W-1:0]     icm_lookup_head_d;
    logic                 icm_rsp_ready_d;
    logic                 cache_get_req_valid_d;
    logic [CHEAD_W-1:0]   cache_get_req_head_d;
    logic                 cache_get_rsp_ready_d;
    logic                 rsp_valid_d;
    logic [HEAD_W-1:0]    rsp_head_d;
    logic [DATA_W-1:0]    rsp_data_d;
    logic                 rsp_last_d;
    logic                 err_opcode_d;

    // Next state, capture registers, and output decode of the next state
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        icm_d        = icm_q;
        phy_d        = phy_q;
        entry_d      = entry_q;
        err_opcode_d = 1'b0;

        case (state_q)
            IDLE: begin
                head_d  = '0;
                icm_d   = '0;
                phy_d   = '0;
                entry_d = '0;
                if (cmd_valid) begin
                    if (cmd_head[123:120] == RD_MPT_QUERY) begin
                        head_d  = cmd_head;
                        state_d = ADDR_REQ;
                    end else begin
                        err_opcode_d = 1'b1;
                    end
                end
            end
            ADDR_REQ:  if (icm_lookup_ready) state_d = ADDR_RSP;
            ADDR_RSP: begin
                if (icm_rsp_valid) begin
                    icm_d   = icm_rsp_icm_addr;
                    phy_d   = icm_rsp_phy_addr;
                    state_d = CACHE_GET;
                end
            end
            CACHE_GET: if (cache_get_req_ready) state_d = CACHE_RSP;
            CACHE_RSP: begin
                if (cache_get_rsp_valid) begin
                    entry_d = cache_get_rsp_data;
                    state_d = BEAT0;
                end
            end
            BEAT0:     if (rsp_ready) state_d = BEAT1;
            BEAT1:     if (rsp_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        cmd_ready_d           = (state_d == IDLE);
        icm_lookup_valid_d    = (state_d == ADDR_REQ);
        icm_lookup_head_d     = '0;
        icm_rsp_ready_d       = (state_d == ADDR_RSP);
        cache_get_req_valid_d = (state_d == CACHE_GET);
        cache_get_req_head_d  = '0;
        cache_get_rsp_ready_d = (state_d == CACHE_RSP);
        rsp_valid_d           = (state_d == BEAT0) || (state_d == BEAT1);
        rsp_head_d            = '0;
        rsp_data_d            = '0;
        rsp_last_d            = (state_d == BEAT1);

        if (state_d == ADDR_REQ)
            icm_lookup_head_d = head_d[64 +: IDX_W];
        // Single-entry get: tag 0, count_max 1, count_index 0
        if (state_d == CACHE_GET)
            cache_get_req_head_d = {TAG_W'(0), CNT_W'(1), CNT_W'(0), phy_d, icm_d};
        if (rsp_valid_d)
            rsp_head_d = head_d;
        if (state_d == BEAT0)
            rsp_data_d = entry_d[DATA_W-1:0];
        else if (state_d == BEAT1)
            rsp_data_d = entry_d[ENTRY_W-1:DATA_W];
    end

    // State, captured fields and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= IDLE;
            head_q              <= '0;
            icm_q               <= '0;
            phy_q               <= '0;
            entry_q             <= '0;
            cmd_ready           <= 1'b1;
            icm_lookup_valid    <= 1'b0;
            icm_lookup_head     <= '0;
            icm_rsp_ready       <= 1'b0;
            cache_get_req_valid <= 1'b0;
            cache_get_req_head  <= '0;
            cache_get_rsp_ready <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_head            <= '0;
            rsp_data            <= '0;
            rsp_last            <= 1'b0;
            err_opcode          <= 1'b0;
        end else begin
            state_q             <= state_d;
            head_q              <= head_d;
            icm_q               <= icm_d;
            phy_q               <= phy_d;
            entry_q             <= entry_d;
            cmd_ready           <= cmd_ready_d;
            icm_lookup_valid    <= icm_lookup_valid_d;
            icm_lookup_head     <= icm_lookup_head_d;
            icm_rsp_ready       <= icm_rsp_ready_d;
            cache_get_req_valid <= cache_get_req_valid_d;
            cache_get_req_head  <= cache_get_req_head_d;
            cache_get_rsp_ready <= cache_get_rsp_ready_d;
            rsp_valid           <= rsp_valid_d;
            rsp_head            <= rsp_head_d;
            rsp_data            <= rsp_data_d;
            rsp_last            <= rsp_last_d;
            err_opcode          <= err_opcode_d;
        end
    end

endmodule

// File: tb/tb_swacc_mr_mpt_query.sv
// Self-checking bench for swacc_mr_mpt_query: the bench plays CEU, ICM lookup and cache peers.
module tb_swacc_mr_mpt_query;

    localparam logic [3:0] RD_MPT_QUERY = 4'h1;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [127:0] cmd_head;
    logic         icm_lookup_valid, icm_lookup_ready;
    logic [18:0]  icm_lookup_head;
    logic         icm_rsp_valid, icm_rsp_ready;
    logic [63:0]  icm_rsp_icm_addr, icm_rsp_phy_addr;
    logic         cache_get_req_valid, cache_get_req_ready;
    logic [149:0] cache_get_req_head;
    logic         cache_get_rsp_valid, cache_get_rsp_ready;
    logic [511:0] cache_get_rsp_data;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_head;
    logic [255:0] rsp_data;
    logic         rsp_last;
    logic         err_opcode;

    int           n_cmp = 0;
    int           n_bad = 0;
    longint       cyc = 0;

    swacc_mr_mpt_query dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_head            (cmd_head),
        .icm_lookup_valid    (icm_lookup_valid),
        .icm_lookup_ready    (icm_lookup_ready),
        .icm_lookup_head     (icm_lookup_head),
        .icm_rsp_valid       (icm_rsp_valid),
        .icm_rsp_ready       (icm_rsp_ready),
        .icm_rsp_icm_addr    (icm_rsp_icm_addr),
        .icm_rsp_phy_addr    (icm_rsp_phy_addr),
        .cache_get_req_valid (cache_get_req_valid),
        .cache_get_req_ready (cache_get_req_ready),
        .cache_get_req_head  (cache_get_req_head),
        .cache_get_rsp_valid (cache_get_rsp_valid),
        .cache_get_rsp_ready (cache_get_rsp_ready),
        .cache_get_rsp_data  (cache_get_rsp_data),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_head            (rsp_head),
        .rsp_data            (rsp_data),
        .rsp_last            (rsp_last),
        .err_opcode          (err_opcode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [511:0] rand_entry();
        logic [511:0] e;
        for (int i = 0; i < 16; i++) e[i*32 +: 32] = $urandom;
        return e;
    endfunction

    function automatic logic [127:0] make_head(input logic [3:0] op, input logic [31:0] idx);
        logic [127:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[123:120] = op;
        h[95:64]   = idx;
        return h;
    endfunction

    // Full query as seen from all peers; stall counts hold ready/valid low for that many cycles.
    // abort_beat0 asserts rst in BEAT0 and checks the query is dropped.
    task automatic query(input logic [31:0] idx, input logic [63:0] icm, input logic [63:0] phy,
                         input logic [511:0] ent, input int sl, input int sr, input int sp,
                         input int dl, input bit early, input bit abort_beat0, output int lat);
        logic [127:0] h;
        logic [149:0] exp_ch;
        logic [18:0]  exp_idx;
        longint       t0;
        h       = make_head(RD_MPT_QUERY, idx);
        exp_idx = idx[18:0];
        exp_ch  = {6'd0, 8'd1, 8'd0, phy, icm};
        lat     = 0;
        check("cmd_ready_idle", 512'(cmd_ready), 512'(1));
        cmd_valid = 1'b1;
        cmd_head  = h;
        t0        = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_head  = '0;

        for (int i = 0; i <= sl; i++) begin
            check("lookup_valid", 512'(icm_lookup_valid), 512'(1));
            check("lookup_head", 512'(icm_lookup_head), 512'(exp_idx));
            check("cmd_ready_busy", 512'(cmd_ready), 512'(0));
            check("icm_rsp_ready_early", 512'(icm_rsp_ready), 512'(0));
            if (i == sl) icm_lookup_ready = 1'b1;
            step();
        end
        icm_lookup_ready = 1'b0;

        for (int i = 0; i <= dl; i++) begin
            check("icm_rsp_ready", 512'(icm_rsp_ready), 512'(1));
            check("lookup_valid_off", 512'(icm_lookup_valid), 512'(0));
            check("cache_rsp_ready_off", 512'(cache_get_rsp_ready), 512'(0));
            if (early && i == 0) begin
                cache_get_rsp_valid = 1'b1;
                cache_get_rsp_data  = ~ent;
            end
            if (i == dl) begin
                icm_rsp_valid    = 1'b1;
                icm_rsp_icm_addr = icm;
                icm_rsp_phy_addr = phy;
            end
            step();
            cache_get_rsp_valid = 1'b0;
        end
        icm_rsp_valid    = 1'b0;
        icm_rsp_icm_addr = ~icm;
        icm_rsp_phy_addr = ~phy;

        for (int i = 0; i <= sr; i++) begin
            check("cache_req_valid", 512'(cache_get_req_valid), 512'(1));
            check("cache_req_head", 512'(cache_get_req_head), 512'(exp_ch));
            check("cmd_ready_busy", 512'(cmd_ready), 512'(0));
            if (i == sr) cache_get_req_ready = 1'b1;
            step();
        end
        cache_get_req_ready = 1'b0;

        for (int i = 0; i <= dl; i++) begin
            check("cache_rsp_ready", 512'(cache_get_rsp_ready), 512'(1));
            check("cache_req_off", 512'(cache_get_req_valid), 512'(0));
            check("cache_head_off", 512'(cache_get_req_head), 512'(0));
            if (i == dl) begin
                cache_get_rsp_valid = 1'b1;
                cache_get_rsp_data  = ent;
            end
            step();
        end
        cache_get_rsp_valid = 1'b0;
        cache_get_rsp_data  = rand_entry();

        for (int i = 0; i <= sp; i++) begin
            check("beat0_valid", 512'(rsp_valid), 512'(1));
            check("beat0_data", 512'(rsp_data), 512'(ent[255:0]));
            check("beat0_last", 512'(rsp_last), 512'(0));
            check("beat0_head", 512'(rsp_head), 512'(h));
            check("cmd_ready_busy", 512'(cmd_ready), 512'(0));
            if (abort_beat0) begin
                rst = 1'b1;
                #1;
                check("rst_rsp_valid", 512'(rsp_valid), 512'(0));
                check("rst_rsp_data", 512'(rsp_data), 512'(0));
                check("rst_cmd_ready", 512'(cmd_ready), 512'(1));
                step();
                rst = 1'b0;
                step();
                check("post_rst_cmd_ready", 512'(cmd_ready), 512'(1));
                check("post_rst_rsp_valid", 512'(rsp_valid), 512'(0));
                return;
            end
            if (i == sp) rsp_ready = 1'b1;
            step();
        end

        rsp_ready = 1'b0;
        for (int i = 0; i <= sp; i++) begin
            check("beat1_valid", 512'(rsp_valid), 512'(1));
            check("beat1_data", 512'(rsp_data), 512'(ent[511:256]));
            check("beat1_last", 512'(rsp_last), 512'(1));
            check("beat1_head", 512'(rsp_head), 512'(h));
            check("cmd_ready_busy", 512'(cmd_ready), 512'(0));
            if (i == sp) rsp_ready = 1'b1;
            step();
        end
        rsp_ready = 1'b0;

        lat = int'(cyc - t0);
        check("cmd_ready_back", 512'(cmd_ready), 512'(1));
        check("rsp_valid_off", 512'(rsp_valid), 512'(0));
        check("rsp_data_off", 512'(rsp_data), 512'(0));
    endtask

    task automatic bad_opcode(input logic [3:0] op);
        cmd_valid = 1'b1;
        cmd_head  = make_head(op, $urandom);
        step();
        cmd_valid = 1'b0;
        check("err_pulse", 512'(err_opcode), 512'(1));
        check("err_cmd_ready", 512'(cmd_ready), 512'(1));
        check("err_no_lookup", 512'(icm_lookup_valid), 512'(0));
        check("err_no_cache", 512'(cache_get_req_valid), 512'(0));
        step();
        check("err_single", 512'(err_opcode), 512'(0));
        check("err_no_lookup2", 512'(icm_lookup_valid), 512'(0));
        check("err_no_cache2", 512'(cache_get_req_valid), 512'(0));
    endtask

    initial begin
        logic [511:0] ramp;
        logic [3:0]   op;
        int           lat;

        rst                 = 1'b1;
        cmd_valid           = 1'b0;
        cmd_head            = '0;
        icm_lookup_ready    = 1'b0;
        icm_rsp_valid       = 1'b0;
        icm_rsp_icm_addr    = '0;
        icm_rsp_phy_addr    = '0;
        cache_get_req_ready = 1'b0;
        cache_get_rsp_valid = 1'b0;
        cache_get_rsp_data  = '0;
        rsp_ready           = 1'b0;
        for (int i = 0; i < 64; i++) ramp[i*8 +: 8] = 8'(i);

        step();
        check("reset_cmd_ready", 512'(cmd_ready), 512'(1));
        check("reset_lookup_valid", 512'(icm_lookup_valid), 512'(0));
        check("reset_icm_rsp_ready", 512'(icm_rsp_ready), 512'(0));
        check("reset_cache_req", 512'(cache_get_req_valid), 512'(0));
        check("reset_cache_rsp_ready", 512'(cache_get_rsp_ready), 512'(0));
        check("reset_rsp_valid", 512'(rsp_valid), 512'(0));
        check("reset_rsp_last", 512'(rsp_last), 512'(0));
        check("reset_err", 512'(err_opcode), 512'(0));
        check("reset_heads", 512'({icm_lookup_head, cache_get_req_head, rsp_head}), 512'(0));
        check("reset_rsp_data", 512'(rsp_data), 512'(0));
        rst = 1'b0;
        step();

        query(32'h1A, 64'h1000, 64'h8000_0000, ramp, 0, 0, 0, 0, 1'b0, 1'b0, lat);
        check("latency", 512'(lat), 512'(7));

        query(32'h1A, 64'h1000, 64'h8000_0000, ramp, 5, 5, 5, 0, 1'b0, 1'b0, lat);
        check("stall_latency", 512'(lat), 512'(7 + 15 + 5));

        bad_opcode(4'hF);

        query(32'd3, $urandom, $urandom, rand_entry(), 0, 0, 0, 0, 1'b0, 1'b0, lat);
        query(32'd7, $urandom, $urandom, rand_entry(), 0, 0, 0, 0, 1'b0, 1'b0, lat);

        query(32'h55, $urandom, $urandom, rand_entry(), 0, 0, 0, 0, 1'b0, 1'b1, lat);
        query(32'h66, {$urandom, $urandom}, {$urandom, $urandom}, rand_entry(), 0, 0, 0, 0, 1'b0, 1'b0, lat);

        query(32'h77, {$urandom, $urandom}, {$urandom, $urandom}, rand_entry(), 0, 0, 0, 2, 1'b1, 1'b0, lat);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 4'($urandom_range(0, 15));
                if (op == RD_MPT_QUERY) op = 4'hF;
                bad_opcode(op);
            end else begin
                query($urandom, {$urandom, $urandom}, {$urandom, $urandom}, rand_entry(),
                      $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, lat);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
